// File: rtl/timer_counter_cmp.sv
// ============================================================================
// timer_counter_cmp : 64-bit timer counter with compare match, sticky status.
// Optional macro TIMER_CNT_SHADOW_EN adds a coherent high-word read shadow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_counter_cmp #(
  parameter logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        count_en,
  input  logic        timer_en,
  input  logic        wr_cnt_lo,
  input  logic        wr_cnt_hi,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic [31:0] wdata,
  input  logic        rd_cnt_lo,
  input  logic        int_en,
  input  logic        int_st_clr,
  output logic [63:0] cnt,
  output logic [63:0] cmp,
  output logic [31:0] cnt_hi_rd,
  output logic        int_st,
  output logic        tim_int
);

  logic [63:0] cnt_q, cnt_d;
  logic [63:0] cmp_q, cmp_d;
  logic        int_st_q, int_st_d;
  logic        timer_en_q;
  logic        w_match;

  assign w_match = (cnt_q == cmp_q);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt_lo || wr_cnt_hi) begin
      if (wr_cnt_lo) cnt_d[31:0]  = wdata;
      if (wr_cnt_hi) cnt_d[63:32] = wdata;
    end else if (timer_en_q && !timer_en) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo) cmp_d[31:0]  = wdata;
    if (wr_cmp_hi) cmp_d[63:32] = wdata;
  end

  // A match wins over a same-cycle clear so the status cannot be lost.
  always_comb begin
    int_st_d = int_st_q;
    if (w_match)         int_st_d = 1'b1;
    else if (int_st_clr) int_st_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      cmp_q      <= CMP_RST_VAL;
      int_st_q   <= 1'b0;
      timer_en_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      int_st_q   <= int_st_d;
      timer_en_q <= timer_en;
    end
  end

`ifdef TIMER_CNT_SHADOW_EN
  logic [31:0] shadow_q, shadow_d;

  // Capture uses the pre-update count so a lo/hi read pair is coherent.
  always_comb begin
    shadow_d = shadow_q;
    if (rd_cnt_lo) shadow_d = cnt_q[63:32];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) shadow_q <= '0;
    else            shadow_q <= shadow_d;
  end

  assign cnt_hi_rd = shadow_q;
`else
  logic unused_rd_cnt_lo;
  assign unused_rd_cnt_lo = rd_cnt_lo;
  assign cnt_hi_rd        = cnt_q[63:32];
`endif

  assign cnt     = cnt_q;
  assign cmp     = cmp_q;
  assign int_st  = int_st_q;
  assign tim_int = int_st_q & int_en;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter_cmp.sv
// ============================================================================
// tb_timer_counter_cmp : directed self-checking bench for timer_counter_cmp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_counter_cmp;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        count_en, timer_en;
  logic        wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi;
  logic [31:0] wdata;
  logic        rd_cnt_lo, int_en, int_st_clr;
  logic [63:0] cnt, cmp;
  logic [31:0] cnt_hi_rd;
  logic        int_st, tim_int;

  int n_checks = 0;
  int n_errors = 0;

  timer_counter_cmp dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .count_en   (count_en),
    .timer_en   (timer_en),
    .wr_cnt_lo  (wr_cnt_lo),
    .wr_cnt_hi  (wr_cnt_hi),
    .wr_cmp_lo  (wr_cmp_lo),
    .wr_cmp_hi  (wr_cmp_hi),
    .wdata      (wdata),
    .rd_cnt_lo  (rd_cnt_lo),
    .int_en     (int_en),
    .int_st_clr (int_st_clr),
    .cnt        (cnt),
    .cmp        (cmp),
    .cnt_hi_rd  (cnt_hi_rd),
    .int_st     (int_st),
    .tim_int    (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_pulses();
    wr_cnt_lo = 0; wr_cnt_hi = 0; wr_cmp_lo = 0; wr_cmp_hi = 0;
    rd_cnt_lo = 0; int_st_clr = 0; count_en = 0;
  endtask

  initial begin
    sys_rst_n = 0; timer_en = 0; int_en = 0; wdata = '0;
    clear_pulses();
    tick(); tick();
    sys_rst_n = 1;
    tick();

    // Reset state
    chk("rst_cnt", cnt, 64'h0);
    chk("rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_int_st", {63'h0, int_st}, 64'h0);
    chk("rst_tim_int", {63'h0, tim_int}, 64'h0);
    chk("rst_cnt_hi_rd", {32'h0, cnt_hi_rd}, 64'h0);

    // Compare = 5, one half at a time
    wr_cmp_hi = 1; wdata = 32'h0; tick();
    wr_cmp_hi = 0; wr_cmp_lo = 1; wdata = 32'h5; tick();
    clear_pulses();
    chk("cmp_write", cmp, 64'h5);

    // Counter wrap
    wr_cnt_lo = 1; wr_cnt_hi = 1; wdata = 32'hFFFF_FFFF; tick();
    clear_pulses();
    chk("wrap_load", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    count_en = 1; tick();
    clear_pulses();
    chk("wrap_zero", cnt, 64'h0);
    chk("wrap_int_st", {63'h0, int_st}, 64'h0);

    // Compare match with continuous counting
    int_en = 1; count_en = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("match_cnt5", cnt, 64'h5);
    chk("match_pre_int_st", {63'h0, int_st}, 64'h0);
    tick();
    chk("match_cnt6", cnt, 64'h6);
    chk("match_int_st", {63'h0, int_st}, 64'h1);
    chk("match_tim_int", {63'h0, tim_int}, 64'h1);
    tick();
    chk("match_cnt7", cnt, 64'h7);
    int_st_clr = 1; tick();
    int_st_clr = 0;
    chk("clr_int_st", {63'h0, int_st}, 64'h0);
    chk("clr_cnt8", cnt, 64'h8);

    // Write beats count_en in the same cycle
    wr_cnt_lo = 1; wdata = 32'h10; tick();
    clear_pulses();
    chk("wr_beats_inc", cnt, 64'h10);

    // Match beats clear in the same cycle
    wr_cnt_lo = 1; wdata = 32'h5; tick();
    clear_pulses();
    chk("pre_match_int_st", {63'h0, int_st}, 64'h0);
    tick();
    chk("hold_match_int_st", {63'h0, int_st}, 64'h1);
    int_st_clr = 1; tick();
    int_st_clr = 0;
    chk("set_beats_clr", {63'h0, int_st}, 64'h1);

    // timer_en falling edge clears the counter; int_en masks tim_int only
    int_en = 0; timer_en = 1;
    wr_cnt_lo = 1; wdata = 32'h1234; tick();
    clear_pulses();
    chk("ten_load", cnt, 64'h1234);
    int_st_clr = 1; tick();
    int_st_clr = 0;
    chk("ten_clr_int_st", {63'h0, int_st}, 64'h0);
    timer_en = 0; tick();
    chk("ten_fall_cnt", cnt, 64'h0);
    wr_cnt_lo = 1; wdata = 32'h5; tick();
    clear_pulses();
    tick();
    chk("masked_int_st", {63'h0, int_st}, 64'h1);
    chk("masked_tim_int", {63'h0, tim_int}, 64'h0);
    int_en = 1; #1;
    chk("unmasked_tim_int", {63'h0, tim_int}, 64'h1);

    // High-word read coherence
    wr_cnt_hi = 1; wdata = 32'h1; tick();
    wr_cnt_hi = 0; wr_cnt_lo = 1; wdata = 32'hFFFF_FFFF; tick();
    clear_pulses();
    chk("shadow_load", cnt, 64'h0000_0001_FFFF_FFFF);
    rd_cnt_lo = 1; count_en = 1; tick();
    clear_pulses();
    chk("shadow_cnt", cnt, 64'h0000_0002_0000_0000);
`ifdef TIMER_CNT_SHADOW_EN
    chk("shadow_hi_rd", {32'h0, cnt_hi_rd}, 64'h1);
`else
    chk("shadow_hi_rd", {32'h0, cnt_hi_rd}, 64'h2);
`endif

    // Reset mid-activity overrides writes and ticks
    count_en = 1; wr_cnt_lo = 1; wr_cmp_lo = 1; wdata = 32'h7; sys_rst_n = 0; tick();
    clear_pulses(); sys_rst_n = 1;
    chk("mid_rst_cnt", cnt, 64'h0);
    chk("mid_rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mid_rst_int_st", {63'h0, int_st}, 64'h0);
    chk("mid_rst_hi_rd", {32'h0, cnt_hi_rd}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
